// File: rtl/multiply_unit_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM encoding, default widths, the XZR index and the counter width helper.
package multiply_unit_pkg;
  localparam int WIDTH_DEF      = 64;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int XZR            = 31;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/multiply_unit_if.sv
// Request/write-back bundle between the issue logic, the multiplier and the register bank.
interface multiply_unit_if
  import multiply_unit_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
  logic                  start;
  logic [WIDTH-1:0]      read_data_one;
  logic [WIDTH-1:0]      read_data_two;
  logic [REG_ADDR_W-1:0] dest_register;
  logic                  high_select;
  logic                  busy;
  logic                  done;
  logic [REG_ADDR_W-1:0] write_register;
  logic [WIDTH-1:0]      write_data;
  logic                  register_write;

  modport master (
    output start, read_data_one, read_data_two, dest_register, high_select,
    input  busy, done, write_register, write_data, register_write
  );

  modport slave (
    input  start, read_data_one, read_data_two, dest_register, high_select,
    output busy, done, write_register, write_data, register_write
  );
endinterface

// File: rtl/multiply_step.sv
// One radix-2 unsigned iteration: conditional add into the upper half, then shift right.
module multiply_step #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);
  logic [WIDTH:0] sum;

  // The carry out of the add becomes the new MSB after the shift.
  assign sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_nxt    = {sum, acc[WIDTH-1:1]};
  assign mplier_nxt = mplier >> 1;
endmodule

// File: rtl/multiply_unit.sv
// Fixed-latency sequential multiplier (MUL / UMULH) with register-bank write-back.
// Operands are captured on the accepting edge; WIDTH shift-add steps follow, then one DONE cycle.
module multiply_unit
  import multiply_unit_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input logic            clk,
  input logic            reset,
  multiply_unit_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_t                state, state_nxt;
  logic [2*WIDTH-1:0]    acc, acc_nxt;
  logic [WIDTH-1:0]      mcand;
  logic [WIDTH-1:0]      mplier, mplier_nxt;
  logic [REG_ADDR_W-1:0] dest;
  logic                  hsel;
  logic [CNT_W-1:0]      cnt;
  logic                  last_step;

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  multiply_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mplier_nxt (mplier_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      dest   <= '0;
      hsel   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mcand  <= bus.read_data_one;
          mplier <= bus.read_data_two;
          dest   <= bus.dest_register;
          hsel   <= bus.high_select;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only, so they hold steady across the bank's falling-edge sample.
  always_comb begin
    bus.busy           = (state != IDLE);
    bus.done           = 1'b0;
    bus.write_data     = '0;
    bus.write_register = '0;
    bus.register_write = 1'b0;
    if (state == DONE) begin
      bus.done           = 1'b1;
      bus.write_data     = hsel ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
      bus.write_register = dest;
      bus.register_write = (dest != REG_ADDR_W'(XZR));
    end
  end
endmodule

// File: tb/tb_multiply_unit.sv
// Scoreboard bench for multiply_unit: driver pushes expected write-backs, negedge monitor pops and checks.
module tb_multiply_unit;
  localparam int W  = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multiply_unit_if #(.WIDTH(W), .REG_ADDR_W(AW)) mif ();
  multiply_unit #(.WIDTH(W), .REG_ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(mif));

  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] rg;
    logic          wr;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [AW-1:0] d, input logic hs, input int c);
    exp_t e;
    logic [2*W-1:0] p;
    p      = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.data = hs ? p[2*W-1:W] : p[W-1:0];
    e.rg   = d;
    e.wr   = (d != 5'd31);
    e.cyc  = c;
    return e;
  endfunction

  task automatic scramble();
    mif.read_data_one = {$urandom, $urandom};
    mif.read_data_two = {$urandom, $urandom};
    mif.dest_register = AW'($urandom_range(0, 31));
    mif.high_select   = 1'($urandom_range(0, 1));
  endtask

  // Drive operands at a negedge; the next rising edge accepts and done is due 65 edges later.
  task automatic present(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] d, input logic hs);
    mif.start         = 1'b1;
    mif.read_data_one = a;
    mif.read_data_two = b;
    mif.dest_register = d;
    mif.high_select   = hs;
    q.push_back(model(a, b, d, hs, cyc + 65));
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] d, input logic hs);
    int n = 0;
    @(negedge clk);
    while (mif.busy && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("idle_timeout", 1'b1, 1'b0);
    present(a, b, d, hs);
    @(posedge clk);
    #1 mif.start = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("done_timeout", W'(q.size()), '0);
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mif.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("write_data",     mif.write_data, e.data);
          chk("write_register", W'(mif.write_register), W'(e.rg));
          chk("register_write", W'(mif.register_write), W'(e.wr));
          chk("latency",        W'(cyc), W'(e.cyc));
          chk("busy_in_done",   W'(mif.busy), 1);
        end
      end else begin
        chk("idle_outputs_zero",
            W'({mif.register_write, mif.write_register}) | mif.write_data, '0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mif.start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(mif.busy), 0);
    chk("reset_outputs", W'({mif.done, mif.register_write, mif.write_register}) | mif.write_data, 0);
    reset = 1'b0;

    issue(64'd3, 64'd5, 5'd2, 1'b0); drain();
    issue('1, '1, 5'd7, 1'b0);      drain();
    issue('1, '1, 5'd8, 1'b1);      drain();
    issue(64'h1_0000_0000, 64'h1_0000_0000, 5'd3, 1'b1); drain();
    issue(64'h1_0000_0000, 64'h1_0000_0000, 5'd4, 1'b0); drain();
    issue(64'd7, 64'd6, 5'd31, 1'b0); drain();
    issue(64'd0, 64'd0, 5'd1, 1'b0);  drain();
    issue(64'd0, '1, 5'd5, 1'b1);     drain();

    for (int i = 0; i < 16; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom},
            AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      drain();
    end

    // Start held high: only one capture per 66-cycle round, operands churn meanwhile.
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      present({$urandom, $urandom}, {$urandom, $urandom},
              AW'($urandom_range(0, 30)), 1'(r & 1));
      @(posedge clk);
      for (int k = 0; k < 66; k++) begin
        @(negedge clk);
        scramble();
      end
    end
    mif.start = 1'b0;
    drain();

    // Reset mid-run aborts without write-back.
    issue(64'd123456789, 64'd987654321, 5'd10, 1'b0);
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", W'(mif.busy), 0);
    chk("abort_done_wr", W'({mif.done, mif.register_write}), 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(64'd4, 64'd4, 5'd9, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
